alu_exec_stage: RTL and testbench

- Registered execute stage that sits directly downstream of the ALU control decoder.
- Takes the 3-bit ALU control code plus two operands, computes the result, and presents result and flags to the memory/writeback side.
- Uses a valid/ready handshake on both sides so upstream stalls and downstream back-pressure never lose or duplicate an operation.

---
 rtl/alu_exec_stage_if.sv | 36 +++
 rtl/alu_exec_stage.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the issue-side and result-side handshakes of the ALU execute stage.
//
// Issue side   : in_valid, in_ready, alu_control, src_a, src_b
// Result side  : out_valid, out_ready, result, zero, illegal, op_count
//
// Modports
//   master : the environment around the stage (drives operations, consumes results)
//   slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [15:0]      op_count;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, op_count
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, op_count
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered execute stage fed by the ALU control decoder. An accepted
// operation is evaluated immediately and its result/zero/illegal flags are
// captured in the output register; they stay frozen while the consumer stalls.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, discards every held entry
//   bus    : alu_exec_stage_if.slave (issue and result handshakes, op_count)
//
// Build option
//   ALU_EXEC_SKID_EN : adds a one-entry skid register so in_ready comes from
//                      a flop (no combinational path from out_ready). Without
//                      it, in_ready = !out_valid || out_ready.
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_stage_if.slave   bus
);

    // One held operation: result plus its two flags, kept together so they
    // can never drift apart between the skid and output registers.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             illegal;
    } entry_t;

    // Evaluates one operation; zero is derived from the result, which also
    // gives a==b for branch-compare and zero=1 for the unmapped codes.
    function automatic entry_t alu_eval(
        input logic [2:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        entry_t           e;
        logic [WIDTH-1:0] r;
        logic             ill;
        ill = 1'b0;
        case (ctrl)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b011:  r = a | b;
            3'b100:  r = a & b;
            3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b111:  r = a - b;
            default: begin
                r   = {WIDTH{1'b0}};
                ill = 1'b1;
            end
        endcase
        e.result  = r;
        e.zero    = (r == {WIDTH{1'b0}});
        e.illegal = ill;
        return e;
    endfunction

    entry_t      new_entry_s;
    entry_t      out_entry_r;
    entry_t      out_entry_nxt_s;
    logic        out_valid_r;
    logic        out_valid_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;
    logic        accept_s;
    logic        complete_s;

`ifdef ALU_EXEC_SKID_EN
    entry_t      skid_entry_r;
    entry_t      skid_entry_nxt_s;
    logic        skid_full_r;
    logic        skid_full_nxt_s;
    logic        in_ready_r;
    logic        out_free_s;

    // Next-state for output and skid registers; the skid always drains first
    // so ordering is preserved.
    always_comb begin
        new_entry_s      = alu_eval(bus.alu_control, bus.src_a, bus.src_b);
        accept_s         = bus.in_valid && in_ready_r;
        complete_s       = out_valid_r && bus.out_ready;
        out_free_s       = !out_valid_r || bus.out_ready;
        out_entry_nxt_s  = out_entry_r;
        out_valid_nxt_s  = out_valid_r;
        skid_entry_nxt_s = skid_entry_r;
        skid_full_nxt_s  = skid_full_r;
        if (out_free_s) begin
            if (skid_full_r) begin
                // in_ready was low, so no new op can arrive this cycle
                out_entry_nxt_s = skid_entry_r;
                out_valid_nxt_s = 1'b1;
                skid_full_nxt_s = 1'b0;
            end else if (accept_s) begin
                out_entry_nxt_s = new_entry_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_entry_nxt_s = new_entry_s;
                skid_full_nxt_s  = 1'b1;
            end else begin
                skid_full_nxt_s  = skid_full_r;
            end
        end
    end

    // Skid register and registered in_ready; in_ready stays low while reset
    // is asserted and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_entry_r <= {(WIDTH+2){1'b0}};
            skid_full_r  <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            skid_entry_r <= skid_entry_nxt_s;
            skid_full_r  <= skid_full_nxt_s;
            in_ready_r   <= !skid_full_nxt_s;
        end
    end

    assign bus.in_ready = in_ready_r;
`else
    logic in_ready_s;

    // Next-state for the output register; a simultaneous accept and
    // completion simply overwrites the departing entry.
    always_comb begin
        new_entry_s     = alu_eval(bus.alu_control, bus.src_a, bus.src_b);
        in_ready_s      = !out_valid_r || bus.out_ready;
        accept_s        = bus.in_valid && in_ready_s;
        complete_s      = out_valid_r && bus.out_ready;
        out_entry_nxt_s = out_entry_r;
        out_valid_nxt_s = out_valid_r;
        if (accept_s) begin
            out_entry_nxt_s = new_entry_s;
            out_valid_nxt_s = 1'b1;
        end else if (complete_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    assign bus.in_ready = in_ready_s;
`endif

    // Saturating completion counter next-state.
    always_comb begin
        count_nxt_s = count_r;
        if (complete_s && (count_r != 16'hFFFF)) begin
            count_nxt_s = count_r + 16'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Output register, valid flag and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_entry_r <= {(WIDTH+2){1'b0}};
            out_valid_r <= 1'b0;
            count_r     <= 16'd0;
        end else begin
            out_entry_r <= out_entry_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            count_r     <= count_nxt_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.result    = out_entry_r.result;
    assign bus.zero      = out_entry_r.zero;
    assign bus.illegal   = out_entry_r.illegal;
    assign bus.op_count  = count_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Scoreboard bench: every accepted operation pushes its expected outcome,
// computed from the operation rules with plain arithmetic; an independent
// monitor pops on every completion and also tracks op_count and the
// hold-while-stalled behaviour.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_stage_if #(.WIDTH(WIDTH)) bus ();
    alu_exec_stage #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned model_count = 0;
    bit          prev_stall = 1'b0;
    exp_t        prev;
    bit          done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the operation table, using 64-bit arithmetic.
    function automatic exp_t ref_op(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        exp_t           e;
        longint unsigned ua, ub, m, r;
        ua = a; ub = b;
        m  = (64'd1 << WIDTH) - 64'd1;
        e.ill = 1'b0;
        case (c)
            3'd0: r = (ua + ub) & m;
            3'd1: r = (ua - ub) & m;
            3'd3: r = ua | ub;
            3'd4: r = ua & ub;
            3'd5: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd7: r = (ua - ub) & m;
            default: begin r = 64'd0; e.ill = 1'b1; end
        endcase
        e.res = r[WIDTH-1:0];
        e.z   = (r == 64'd0);
        return e;
    endfunction

    // Monitor: samples on the falling edge, the transfer it sees completes
    // on the following rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                check("op_count", {48'd0, bus.op_count}, {32'd0, model_count});
                if (prev_stall) begin
                    check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                    check("hold_result", {32'd0, bus.result}, {32'd0, prev.res});
                    check("hold_flags", {62'd0, bus.zero, bus.illegal}, {62'd0, prev.z, prev.ill});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output got=%0h required=none", bus.result);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", {32'd0, bus.result}, {32'd0, e.res});
                        check("zero", {63'd0, bus.zero}, {63'd0, e.z});
                        check("illegal", {63'd0, bus.illegal}, {63'd0, e.ill});
                    end
                    if (model_count < 32'd65535) model_count++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev.res   = bus.result;
                prev.z     = bus.zero;
                prev.ill   = bus.illegal;
            end
        end
    end

    // Offers one op (caller is just after a rising edge); returns just after
    // the accepting edge.
    task automatic drive(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit acc = 1'b0;
        int k = 0;
        bus.alu_control = c; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
        while (!acc && k < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(ref_op(c, a, b));
                acc = 1'b1;
            end
            k++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout got=in_ready_low required=accept");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 500) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d pending required=0", sb_q.size());
        end
    endtask

    task automatic reset_checks();
        logic exp_rdy;
`ifdef ALU_EXEC_SKID_EN
        exp_rdy = 1'b0;
`else
        exp_rdy = 1'b1;
`endif
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        check("rst_zero", {63'd0, bus.zero}, 64'd0);
        check("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        check("rst_op_count", {48'd0, bus.op_count}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    endtask

    // Asserts reset between edges, checks it took effect at once, releases.
    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        sb_q.delete();
        model_count = 0;
        prev_stall  = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.alu_control = 3'd0;
        bus.src_a = '0; bus.src_b = '0; bus.out_ready = 1'b1;
        #2;
        reset_checks();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

        // basic ops, back to back
        drive(3'd0, 32'd5, 32'd7);
        drive(3'd1, 32'd5, 32'd7);
        drive(3'd5, 32'd5, 32'd7);
        drive(3'd7, 32'd5, 32'd7);
        drain();
        check("basic_count", {48'd0, bus.op_count}, 64'd4);

        // branch-compare equal, illegal codes
        drive(3'd7, 32'h1234, 32'h1234);
        drive(3'd2, 32'd3, 32'd4);
        drive(3'd6, 32'd3, 32'd4);
        drain();
        check("illegal_count", {48'd0, bus.op_count}, 64'd7);

        // reset while an op is stalled at the output
        bus.out_ready = 1'b0;
        drive(3'd0, 32'd9, 32'd9);
        do_reset();
        bus.out_ready = 1'b1;
        drive(3'd1, 32'd10, 32'd3);
        drain();
        check("post_reset_count", {48'd0, bus.op_count}, 64'd1);

        // back-pressure with streaming ADDs
        bus.out_ready = 1'b0;
        fork
            begin
                drive(3'd0, 32'd1, 32'd1);
                drive(3'd0, 32'd2, 32'd2);
                drive(3'd0, 32'd3, 32'd3);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
                check("bp_result", {32'd0, bus.result}, 64'd2);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // randomized traffic with random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [WIDTH-1:0] a, b;
                    a = (i % 3 == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
                    b = (i % 8 == 0) ? a : WIDTH'($urandom);
                    drive(3'($urandom_range(0, 7)), a, b);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // counter saturation
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            drive(3'd0, WIDTH'(i), 32'd1);
        end
        drain();
        check("sat_count", {48'd0, bus.op_count}, 64'hFFFF);
        drive(3'd4, 32'hF0F0, 32'h0FF0);
        drive(3'd3, 32'hF000, 32'h000F);
        drain();
        check("sat_hold", {48'd0, bus.op_count}, 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
